// File: rtl/tmr_mismatch_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : tmr_mismatch_monitor_if
// Description : Replica inputs, voted output and error-event handshake of the
//               TMR mismatch monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface tmr_mismatch_monitor_if #(
  parameter int bits = 1
);
  logic [bits-1:0] r0;
  logic [bits-1:0] r1;
  logic [bits-1:0] r2;
  logic [bits-1:0] voted;
  logic            err_valid;
  logic            err_ready;
  logic [2:0]      err_mask;
  logic [bits-1:0] err_syndrome;

  modport master (
    input  r0, r1, r2, err_ready,
    output voted, err_valid, err_mask, err_syndrome
  );

  modport slave (
    output r0, r1, r2, err_ready,
    input  voted, err_valid, err_mask, err_syndrome
  );
endinterface
`default_nettype wire

// File: rtl/tmr_mismatch_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tmr_mismatch_monitor
// Description : Majority voter over three replica buses with mismatch event
//               reporting, sticky flags and saturating per-replica counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_mismatch_monitor #(
  parameter int bits  = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  tmr_mismatch_monitor_if.master bus,
  output logic                   err_drop,
  output logic                   any_err,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1,
  output logic [CNT_W-1:0]       cnt2
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [bits-1:0]   voted_q, voted_d;
  logic [2:0]        mask_q, mask_d;
  logic [bits-1:0]   syn_q, syn_d;
  logic              drop_q, drop_d;
  logic              any_q, any_d;
  logic [CNT_W-1:0]  cnt_q [3];
  logic [CNT_W-1:0]  cnt_d [3];

  logic [bits-1:0]   w_maj;
  logic [bits-1:0]   w_d0, w_d1, w_d2;
  logic [bits-1:0]   w_syn;
  logic [2:0]        w_mask;
  logic              w_hit;

  assign w_maj  = (bus.r0 & bus.r1) | (bus.r0 & bus.r2) | (bus.r1 & bus.r2);
  assign w_d0   = bus.r0 ^ w_maj;
  assign w_d1   = bus.r1 ^ w_maj;
  assign w_d2   = bus.r2 ^ w_maj;
  assign w_mask = {|w_d2, |w_d1, |w_d0};
  assign w_syn  = w_d0 | w_d1 | w_d2;
  assign w_hit  = en & (|w_mask);

  always_comb begin
    state_d = state_q;
    voted_d = w_maj;
    mask_d  = mask_q;
    syn_d   = syn_q;
    drop_d  = drop_q;
    any_d   = any_q | w_hit;

    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_hit && w_mask[i] && (cnt_q[i] != c_cnt_max)) begin
        cnt_d[i] = cnt_q[i] + c_cnt_one;
      end
    end

    case (state_q)
      IDLE: begin
        if (w_hit) begin
          mask_d  = w_mask;
          syn_d   = w_syn;
          state_d = PEND;
        end
      end
      PEND: begin
        if (bus.err_ready) begin
          if (w_hit) begin
            mask_d = w_mask;
            syn_d  = w_syn;
          end else begin
            state_d = IDLE;
          end
        end else if (w_hit) begin
          // Consumer is stalled: keep the old payload, remember the loss.
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear touches only the statistics, never the event path.
    if (clr) begin
      drop_d = 1'b0;
      any_d  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      voted_q <= '0;
      mask_q  <= '0;
      syn_q   <= '0;
      drop_q  <= 1'b0;
      any_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      voted_q <= voted_d;
      mask_q  <= mask_d;
      syn_q   <= syn_d;
      drop_q  <= drop_d;
      any_q   <= any_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.voted        = voted_q;
  assign bus.err_valid    = (state_q == PEND);
  assign bus.err_mask     = mask_q;
  assign bus.err_syndrome = syn_q;
  assign err_drop         = drop_q;
  assign any_err          = any_q;
  assign cnt0             = cnt_q[0];
  assign cnt1             = cnt_q[1];
  assign cnt2             = cnt_q[2];

endmodule
`default_nettype wire

// File: doc/tmr_mismatch_monitor.md
TMR_MISMATCH_MONITOR -- requirements
Module: tmr_mismatch_monitor

Interface
REQ-001 The block SHALL have parameter bits, default 1: width of each replica bus.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of each per-replica fault counter.
REQ-003 The block SHALL have port clk, input, 1: sole clock; all state rising-edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1: detection enable; when low, no event, count or sticky update occurs.
REQ-006 The block SHALL have port clr, input, 1: synchronous clear of counters, any_err and err_drop.
REQ-007 The block SHALL have ports r0, r1, r2, input, bits each: the three replica register outputs.
REQ-008 The block SHALL have port voted, output, bits: registered bitwise majority of r0/r1/r2.
REQ-009 The block SHALL have port err_valid, output, 1: an error event is pending.
REQ-010 The block SHALL have port err_ready, input, 1: consumer accepts the pending event.
REQ-011 The block SHALL have port err_mask, output, 3: bit i set means replica ri disagreed with the majority.
REQ-012 The block SHALL have port err_syndrome, output, bits: bit positions where any replica disagreed.
REQ-013 The block SHALL have port err_drop, output, 1: sticky flag, an event was lost while one was pending.
REQ-014 The block SHALL have port any_err, output, 1: sticky flag, any mismatch detected since the last clr or reset.
REQ-015 The block SHALL have ports cnt0, cnt1, cnt2, output, CNT_W each: saturating per-replica fault counts.

Function
REQ-016 The block SHALL compute maj = (r0&r1)|(r0&r2)|(r1&r2) and di = ri^maj; mask[i] = OR-reduce(di); syn = d0|d1|d2.
REQ-017 The block SHALL set hit = en AND (mask != 0), evaluated combinationally on the current inputs.
REQ-018 The block SHALL register voted <= maj on every edge, independent of en, giving 1-cycle latency.
REQ-019 On a hit edge, the block SHALL add 1 to cnt[i] for each set mask[i], saturating at 2^CNT_W-1 with no wrap.
REQ-020 On a hit edge, the block SHALL set any_err.
REQ-021 The block SHALL give clr priority over same-edge increments and sticky sets; the result after that edge is counters 0, any_err 0, err_drop 0.
REQ-022 The event FSM SHALL have states IDLE (err_valid=0) and PEND (err_valid=1).
REQ-023 In IDLE, on hit, the FSM SHALL load err_mask<=mask and err_syndrome<=syn and go to PEND, so err_valid is high in the cycle after the offending inputs.
REQ-024 In PEND with err_ready=1 and hit, the FSM SHALL load the new payload and stay in PEND (back-to-back, no bubble).
REQ-025 In PEND with err_ready=1 and no hit, the FSM SHALL return to IDLE.
REQ-026 In PEND with err_ready=0, err_mask and err_syndrome SHALL stay stable.
REQ-027 In PEND with err_ready=0, a hit SHALL be discarded and SHALL set err_drop; counters and any_err SHALL still update.
REQ-028 clr SHALL NOT affect the FSM state or the pending payload.
REQ-029 In IDLE, err_mask and err_syndrome SHALL hold their last values; they are meaningful only while err_valid=1.

Reset
REQ-030 On rst assertion, the block SHALL immediately, without waiting for a clock edge, drive state=IDLE, err_valid=0, err_mask=0, err_syndrome=0, err_drop=0, any_err=0, cnt0..cnt2=0 and voted=0.
REQ-031 A reset asserted while in PEND SHALL discard the pending event without setting err_drop.
REQ-032 After rst deasserts, the first edge SHALL behave as a normal IDLE edge.

Verification (bits=8, CNT_W=4)
REQ-033 The bench SHALL cover: r0=r1=r2=0xA5, en=1 -> next cycle voted=0xA5, err_valid=0, all counters 0.
REQ-034 The bench SHALL cover: r1=0xA4, r0=r2=0xA5 -> next cycle err_valid=1, err_mask=3'b010, err_syndrome=0x01, cnt1=1, voted=0xA5, any_err=1.
REQ-035 The bench SHALL cover: event pending with err_ready=0, then r2=0x25 with r0=r1=0xA5 -> payload unchanged (mask 010, syn 0x01), err_drop=1, cnt2=1; then err_ready=1 -> err_valid=0 next cycle.
REQ-036 The bench SHALL cover: r0 faulty for 20 consecutive cycles, err_ready=1 -> err_valid high throughout, cnt0 saturates at 15, no err_drop.
REQ-037 The bench SHALL cover: clr asserted on the same edge as a hit -> counters 0, any_err 0, err_drop 0, yet err_valid=1 with the new payload.
REQ-038 The bench SHALL cover: rst asserted mid-PEND, between clock edges -> err_valid, counters and voted go to 0 immediately; en=0 with mismatching inputs afterwards -> no event and counters remain 0.
